// File: rtl/aritmetik_birim_if.sv
// Handshake/bus bundle for aritmetik_birim: start strobe, opcode and operands
// towards the unit, result and status flags back.
interface aritmetik_birim_if #(
  parameter int GENISLIK = 32
);
  logic                  basla;
  logic [1:0]            islem;
  logic [GENISLIK-1:0]   sayi1;
  logic [GENISLIK-1:0]   sayi2;
  logic [2*GENISLIK-1:0] sonuc;
  logic                  hazir;
  logic                  gecerli;
  logic                  tasma;

  modport master (output basla, islem, sayi1, sayi2,
                  input  sonuc, hazir, gecerli, tasma);
  modport slave  (input  basla, islem, sayi1, sayi2,
                  output sonuc, hazir, gecerli, tasma);
endinterface

// File: rtl/aritmetik_birim.sv
// Sequential arithmetic unit: cikarma (1 cycle), carpma and bolme
// (radix-2, 32 iterations on magnitudes, sign fixed up at the end).
// Build option: define ISARETLI_EN for two's-complement operands;
// left undefined, every operand is treated as unsigned.
module aritmetik_birim #(
  parameter int GENISLIK = 32
) (
  input  logic            clk,
  input  logic            rst,
  aritmetik_birim_if.slave bus
);
  localparam int W  = GENISLIK;
  localparam int SW = $clog2(W) + 1;
`ifdef ISARETLI_EN
  localparam bit ISARETLI = 1'b1;
`else
  localparam bit ISARETLI = 1'b0;
`endif
  localparam logic [1:0] CIK = 2'b00, CARP = 2'b01, BOL = 2'b10;

  typedef enum logic [1:0] {IDLE, HESAP, BITTI} durum_t;

  durum_t          durum;
  logic [1:0]      op;
  logic [2*W-1:0]  p;        // cikarma: {a,b}; carpma: product/multiplier; bolme: {rem,quo}
  logic [W-1:0]    m;        // multiplicand or divisor magnitude
  logic            neg_a, neg_b, ozel;
  logic [SW-1:0]   sayac;
  logic [2*W-1:0]  sonuc_r;
  logic            hazir_r, gecerli_r, tasma_r;

  assign bus.sonuc   = sonuc_r;
  assign bus.hazir   = hazir_r;
  assign bus.gecerli = gecerli_r;
  assign bus.tasma   = tasma_r;

  // operand signs and magnitudes, used only on the start edge
  logic         a_neg, b_neg;
  logic [W-1:0] a_mag, b_mag;
  assign a_neg = ISARETLI && bus.sayi1[W-1];
  assign b_neg = ISARETLI && bus.sayi2[W-1];
  assign a_mag = a_neg ? -bus.sayi1 : bus.sayi1;
  assign b_mag = b_neg ? -bus.sayi2 : bus.sayi2;

  // one shift-add step: add multiplicand into the high half, shift right
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
  assign mul_sum  = {1'b0, p[2*W-1:W]} + (p[0] ? {1'b0, m} : '0);
  assign mul_next = {mul_sum, p[W-1:1]};

  // one restoring-division step on {rem,quo}
  logic [W+1:0]   div_sh, div_fark;
  logic [2*W-1:0] div_next;
  assign div_sh   = {1'b0, p[2*W-1:W], p[W-1]};
  assign div_fark = div_sh - {2'b00, m};
  assign div_next = div_fark[W+1] ? {p[2*W-2:0], 1'b0}
                                  : {div_fark[W-1:0], p[W-2:0], 1'b1};

  // final result/flags and whether this HESAP cycle is the completing one
  logic [W-1:0]   fark, bolum, kalan;
  logic [2*W-1:0] carpim, sonuc_son;
  logic           tasma_son, gecerli_son, son_adim;
  always_comb begin
    fark        = p[2*W-1:W] - p[W-1:0];
    carpim      = (neg_a ^ neg_b) ? -p : p;
    bolum       = (neg_a ^ neg_b) ? -p[W-1:0] : p[W-1:0];
    kalan       = neg_a ? -p[2*W-1:W] : p[2*W-1:W];
    sonuc_son   = '0;
    tasma_son   = 1'b0;
    gecerli_son = 1'b0;
    son_adim    = (sayac == SW'(W));
    case (op)
      CIK: begin
        son_adim    = 1'b1;
        gecerli_son = 1'b1;
        if (ISARETLI) begin
          sonuc_son = {{W{fark[W-1]}}, fark};
          tasma_son = (p[2*W-1] ^ p[W-1]) & (fark[W-1] ^ p[2*W-1]);
        end else begin
          sonuc_son = {{W{1'b0}}, fark};
          tasma_son = (p[2*W-1:W] < p[W-1:0]);
        end
      end
      CARP: begin
        gecerli_son = 1'b1;
        sonuc_son   = carpim;
        tasma_son   = ISARETLI ? ~((&carpim[2*W-1:W-1]) | ~(|carpim[2*W-1:W-1]))
                               : (|carpim[2*W-1:W]);
      end
      BOL: begin
        if (m == '0) begin
          son_adim = 1'b1;          // divide by zero: immediate, invalid result
        end else begin
          gecerli_son = 1'b1;
          sonuc_son   = {kalan, bolum};
          tasma_son   = ozel;
        end
      end
      default: son_adim = 1'b1;     // reserved opcode
    endcase
  end

  // control FSM plus datapath registers; start accepted whenever hazir=1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      durum     <= IDLE;
      op        <= CIK;
      p         <= '0;
      m         <= '0;
      neg_a     <= 1'b0;
      neg_b     <= 1'b0;
      ozel      <= 1'b0;
      sayac     <= '0;
      sonuc_r   <= '0;
      hazir_r   <= 1'b1;
      gecerli_r <= 1'b0;
      tasma_r   <= 1'b0;
    end else begin
      case (durum)
        HESAP: begin
          if (son_adim) begin
            sonuc_r   <= sonuc_son;
            gecerli_r <= gecerli_son;
            tasma_r   <= tasma_son;
            hazir_r   <= 1'b1;
            durum     <= BITTI;
          end else begin
            p     <= (op == CARP) ? mul_next : div_next;
            sayac <= sayac + SW'(1);
          end
        end
        default: begin
          if (bus.basla) begin
            op    <= bus.islem;
            neg_a <= a_neg;
            neg_b <= b_neg;
            ozel  <= ISARETLI && (bus.sayi1 == {1'b1, {(W-1){1'b0}}}) && (bus.sayi2 == '1);
            m     <= (bus.islem == CARP) ? a_mag : b_mag;
            case (bus.islem)
              CIK:     p <= {bus.sayi1, bus.sayi2};
              CARP:    p <= {{W{1'b0}}, b_mag};
              BOL:     p <= {{W{1'b0}}, a_mag};
              default: p <= '0;
            endcase
            sayac   <= '0;
            hazir_r <= 1'b0;
            durum   <= HESAP;
          end else begin
            durum <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_aritmetik_birim.sv
// Scoreboard bench for aritmetik_birim; expectations come from a behavioural
// model that follows the ISARETLI_EN build option.
module tb_aritmetik_birim;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aritmetik_birim_if #(.GENISLIK(32)) bus();
  aritmetik_birim #(.GENISLIK(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

`ifdef ISARETLI_EN
  localparam bit S = 1'b1;
`else
  localparam bit S = 1'b0;
`endif

  typedef struct {
    logic [63:0] sonuc;
    logic        gecerli;
    logic        tasma;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] o_sonuc;
  logic        o_gec, o_tas, o_hbas;
  int          o_lat;

  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint la, lb, lr, q, rr;
    int     ri;
    e.sonuc = '0; e.gecerli = 1'b0; e.tasma = 1'b0; e.lat = 1;
    if (S) begin la = $signed(a); lb = $signed(b); end
    else   begin la = {32'b0, a}; lb = {32'b0, b}; end
    case (op)
      2'b00: begin
        lr = la - lb;
        ri = a - b;
        e.gecerli = 1'b1;
        if (S) begin e.sonuc = ri; e.tasma = (lr != ri); end
        else   begin e.sonuc = {32'b0, ri}; e.tasma = (a < b); end
      end
      2'b01: begin
        lr = la * lb;
        ri = lr[31:0];
        e.lat = 33; e.gecerli = 1'b1; e.sonuc = lr;
        e.tasma = S ? (lr != ri) : (lr[63:32] != 0);
      end
      2'b10: begin
        if (b != 0) begin
          q  = la / lb;
          rr = la % lb;
          e.lat = 33; e.gecerli = 1'b1;
          e.sonuc = {rr[31:0], q[31:0]};
          e.tasma = S && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        end
      end
      default: ;
    endcase
    return e;
  endfunction

  // issue one operation at the next edge and wait for hazir; tut keeps basla
  // high and scrambles the inputs while the unit is busy
  task automatic islem_yap(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit tut);
    @(negedge clk);
    bus.basla = 1'b1; bus.islem = op; bus.sayi1 = a; bus.sayi2 = b;
    @(posedge clk); #1;
    o_hbas = bus.hazir;
    if (tut) begin
      bus.sayi1 = $urandom; bus.sayi2 = $urandom; bus.islem = 2'($urandom_range(0, 3));
    end else begin
      bus.basla = 1'b0;
    end
    o_lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      o_lat++;
      if (bus.hazir === 1'b1) break;
    end
    bus.basla = 1'b0;
    o_sonuc = bus.sonuc; o_gec = bus.gecerli; o_tas = bus.tasma;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    n_cmp++; if (bus.sonuc !== 64'd0) begin n_err++; $display("FAIL reset sonuc got=%h exp=0", bus.sonuc); end
    n_cmp++; if (bus.hazir !== 1'b1) begin n_err++; $display("FAIL reset hazir got=%b exp=1", bus.hazir); end
    n_cmp++; if (bus.gecerli !== 1'b0) begin n_err++; $display("FAIL reset gecerli got=%b exp=0", bus.gecerli); end
    n_cmp++; if (bus.tasma !== 1'b0) begin n_err++; $display("FAIL reset tasma got=%b exp=0", bus.tasma); end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_cikarma();
    logic [31:0] ta[6], tb[6];
    exp_t e;
    ta = '{32'd7, 32'h7FFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'd0};
    tb = '{32'd10, 32'hFFFF_FFFF, 32'd3, 32'd1, 32'd0, 32'd0};
    ta[5] = $urandom; tb[5] = $urandom;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(model(2'b00, ta[i], tb[i]));
      islem_yap(2'b00, ta[i], tb[i], 1'b0);
      e = exp_q.pop_front();
      n_cmp++; if (o_hbas !== 1'b0) begin n_err++; $display("FAIL cikarma[%0d] hazir_bas got=%b exp=0", i, o_hbas); end
      n_cmp++; if (o_sonuc !== e.sonuc) begin n_err++; $display("FAIL cikarma[%0d] sonuc got=%h exp=%h", i, o_sonuc, e.sonuc); end
      n_cmp++; if ({o_gec, o_tas} !== {e.gecerli, e.tasma}) begin n_err++; $display("FAIL cikarma[%0d] gec/tas got=%b%b exp=%b%b", i, o_gec, o_tas, e.gecerli, e.tasma); end
      n_cmp++; if (o_lat != e.lat) begin n_err++; $display("FAIL cikarma[%0d] latency got=%0d exp=%0d", i, o_lat, e.lat); end
    end
  endtask

  task automatic test_carpma();
    logic [31:0] ta[6], tb[6];
    exp_t e;
    ta = '{32'h0001_0000, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd0, 32'd0};
    tb = '{32'h0001_0000, 32'd5, 32'hFFFF_FFFF, 32'd2, 32'd123, 32'd0};
    ta[5] = $urandom; tb[5] = $urandom;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(model(2'b01, ta[i], tb[i]));
      islem_yap(2'b01, ta[i], tb[i], 1'b0);
      e = exp_q.pop_front();
      n_cmp++; if (o_hbas !== 1'b0) begin n_err++; $display("FAIL carpma[%0d] hazir_bas got=%b exp=0", i, o_hbas); end
      n_cmp++; if (o_sonuc !== e.sonuc) begin n_err++; $display("FAIL carpma[%0d] sonuc got=%h exp=%h", i, o_sonuc, e.sonuc); end
      n_cmp++; if ({o_gec, o_tas} !== {e.gecerli, e.tasma}) begin n_err++; $display("FAIL carpma[%0d] gec/tas got=%b%b exp=%b%b", i, o_gec, o_tas, e.gecerli, e.tasma); end
      n_cmp++; if (o_lat != e.lat) begin n_err++; $display("FAIL carpma[%0d] latency got=%0d exp=%0d", i, o_lat, e.lat); end
    end
  endtask

  task automatic test_bolme();
    logic [31:0] ta[7], tb[7];
    exp_t e;
    ta = '{32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'd100, 32'd7, 32'hFFFF_FFFF, 32'd0};
    tb = '{32'd2, 32'd0, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFFE, 32'h8000_0000, 32'd0};
    ta[6] = $urandom; tb[6] = $urandom_range(1, 1000);
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(model(2'b10, ta[i], tb[i]));
      islem_yap(2'b10, ta[i], tb[i], 1'b0);
      e = exp_q.pop_front();
      n_cmp++; if (o_hbas !== 1'b0) begin n_err++; $display("FAIL bolme[%0d] hazir_bas got=%b exp=0", i, o_hbas); end
      n_cmp++; if (o_sonuc !== e.sonuc) begin n_err++; $display("FAIL bolme[%0d] sonuc got=%h exp=%h", i, o_sonuc, e.sonuc); end
      n_cmp++; if ({o_gec, o_tas} !== {e.gecerli, e.tasma}) begin n_err++; $display("FAIL bolme[%0d] gec/tas got=%b%b exp=%b%b", i, o_gec, o_tas, e.gecerli, e.tasma); end
      n_cmp++; if (o_lat != e.lat) begin n_err++; $display("FAIL bolme[%0d] latency got=%0d exp=%0d", i, o_lat, e.lat); end
    end
  endtask

  task automatic test_ayrik();
    exp_t e;
    exp_q.push_back(model(2'b11, 32'd9, 32'd4));
    islem_yap(2'b11, 32'd9, 32'd4, 1'b0);
    e = exp_q.pop_front();
    n_cmp++; if (o_sonuc !== e.sonuc) begin n_err++; $display("FAIL ayrik sonuc got=%h exp=%h", o_sonuc, e.sonuc); end
    n_cmp++; if ({o_gec, o_tas} !== {e.gecerli, e.tasma}) begin n_err++; $display("FAIL ayrik gec/tas got=%b%b exp=%b%b", o_gec, o_tas, e.gecerli, e.tasma); end
    n_cmp++; if (o_lat != e.lat) begin n_err++; $display("FAIL ayrik latency got=%0d exp=%0d", o_lat, e.lat); end
  endtask

  // basla held high and operands scrambled while busy, then back-to-back ops
  task automatic test_back_to_back();
    logic [1:0]  to[4];
    logic [31:0] ta[4], tb[4];
    exp_t e;
    to = '{2'b01, 2'b00, 2'b10, 2'b01};
    ta = '{32'hFFFF_FFFD, 32'd1, 32'd1000, 32'h1234_5678};
    tb = '{32'd7, 32'd2, 32'd33, 32'h0000_0100};
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(model(to[i], ta[i], tb[i]));
      islem_yap(to[i], ta[i], tb[i], (i == 0));
      e = exp_q.pop_front();
      n_cmp++; if (o_sonuc !== e.sonuc) begin n_err++; $display("FAIL b2b[%0d] sonuc got=%h exp=%h", i, o_sonuc, e.sonuc); end
      n_cmp++; if ({o_gec, o_tas} !== {e.gecerli, e.tasma}) begin n_err++; $display("FAIL b2b[%0d] gec/tas got=%b%b exp=%b%b", i, o_gec, o_tas, e.gecerli, e.tasma); end
      n_cmp++; if (o_lat != e.lat) begin n_err++; $display("FAIL b2b[%0d] latency got=%0d exp=%0d", i, o_lat, e.lat); end
    end
    @(posedge clk); #1;
    n_cmp++; if (bus.hazir !== 1'b1) begin n_err++; $display("FAIL b2b idle hazir got=%b exp=1", bus.hazir); end
  endtask

  task automatic test_reset_ortada();
    exp_t e;
    @(negedge clk);
    bus.basla = 1'b1; bus.islem = 2'b01; bus.sayi1 = 32'd1234; bus.sayi2 = 32'd5678;
    @(posedge clk); #1 bus.basla = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (bus.sonuc !== 64'd0) begin n_err++; $display("FAIL rst_orta sonuc got=%h exp=0", bus.sonuc); end
    n_cmp++; if (bus.hazir !== 1'b1) begin n_err++; $display("FAIL rst_orta hazir got=%b exp=1", bus.hazir); end
    n_cmp++; if ({bus.gecerli, bus.tasma} !== 2'b00) begin n_err++; $display("FAIL rst_orta gec/tas got=%b%b exp=00", bus.gecerli, bus.tasma); end
    @(negedge clk); rst = 1'b1;
    exp_q.push_back(model(2'b01, 32'hFFFF_FFFD, 32'd5));
    islem_yap(2'b01, 32'hFFFF_FFFD, 32'd5, 1'b0);
    e = exp_q.pop_front();
    n_cmp++; if (o_sonuc !== e.sonuc) begin n_err++; $display("FAIL rst_sonra sonuc got=%h exp=%h", o_sonuc, e.sonuc); end
    n_cmp++; if ({o_gec, o_tas} !== {e.gecerli, e.tasma}) begin n_err++; $display("FAIL rst_sonra gec/tas got=%b%b exp=%b%b", o_gec, o_tas, e.gecerli, e.tasma); end
    n_cmp++; if (o_lat != e.lat) begin n_err++; $display("FAIL rst_sonra latency got=%0d exp=%0d", o_lat, e.lat); end
  endtask

  initial begin
    bus.basla = 1'b0; bus.islem = 2'b00; bus.sayi1 = '0; bus.sayi2 = '0;
    test_reset();
    test_cikarma();
    test_carpma();
    test_bolme();
    test_ayrik();
    test_back_to_back();
    test_reset_ortada();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
